// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing logic: opcode field layout,
// functional unit encodings and the arbiter/sequencer state type.
package alu_pkg;

  localparam int OP_W        = 6;
  localparam int DATA_W      = 32;

  // Opcode field positions: [5:4] picks the unit, bit 3 selects add/subtract.
  localparam int UNIT_SEL_HI = 5;
  localparam int UNIT_SEL_LO = 4;
  localparam int ADDSUB_BIT  = 3;

  localparam logic [1:0] UNIT_ADDSUB = 2'b00;
  localparam logic [1:0] UNIT_CMP    = 2'b01;
  localparam logic [1:0] UNIT_LOGIC  = 2'b10;
  localparam logic [1:0] UNIT_SHIFT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin search: starting at prio and wrapping modulo
// NUM_REQ, the first asserted request wins.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    prio,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  int cand;

  // Walk the requesters in rotated order and keep only the first hit.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_any    = 1'b0;
    cand         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(prio) + k) % NUM_REQ;
      if (!grant_any && req_valid[cand]) begin
        grant_any          = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_idx          = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU among
// NUM_REQ requesters. One request is accepted in IDLE, its operands drive
// the ALU for one EXEC cycle, and the captured result is returned in RESP.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*OP_W-1:0]  req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [OP_W-1:0]          alu_op,
  input  logic [DATA_W-1:0]        alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     busy,
  output logic [15:0]              op_count
);

  arb_state_t          state_q, state_d;
  logic [ID_W-1:0]     prio_q, prio_d;
  logic [ID_W-1:0]     cur_id_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [15:0]         op_count_q;

  logic [NUM_REQ-1:0]  grant_onehot;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic                req_hs;
  logic                rsp_hs;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid    (req_valid),
    .prio         (prio_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_any    (grant_any)
  );

  assign req_hs = (state_q == ST_IDLE) && grant_any;
  assign rsp_hs = (state_q == ST_RESP) && rsp_ready;

  // Priority moves to the requester just after the one granted.
  always_comb begin
    prio_d = prio_q;
    if (req_hs) begin
      if (grant_idx == ID_W'(NUM_REQ - 1)) prio_d = '0;
      else                                 prio_d = grant_idx + ID_W'(1);
    end
  end

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: accept in IDLE, one ALU cycle in EXEC, wait for rsp_ready in RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_any) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = grant_onehot;
      ST_EXEC: busy = 1'b1;
      ST_RESP: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture on accept, result capture after EXEC, completion count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= '0;
      cur_id_q   <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      op_count_q <= '0;
    end else begin
      prio_q <= prio_d;
      if (req_hs) begin
        op_q     <= req_op[int'(grant_idx)*OP_W +: OP_W];
        a_q      <= req_a[int'(grant_idx)*DATA_W +: DATA_W];
        b_q      <= req_b[int'(grant_idx)*DATA_W +: DATA_W];
        cur_id_q <= grant_idx;
      end
      if (state_q == ST_EXEC) rsp_data_q <= alu_result;
      if (rsp_hs)             op_count_q <= op_count_q + 16'd1;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign rsp_id   = cur_id_q;
  assign rsp_data = rsp_data_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes hand-computed responses,
// a monitor pops and compares on every response handshake.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } rsp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      reqValid;
  logic [NUM_REQ-1:0]      reqReady;
  logic [NUM_REQ*6-1:0]    reqOp;
  logic [NUM_REQ*32-1:0]   reqA;
  logic [NUM_REQ*32-1:0]   reqB;
  logic [31:0]             aluA, aluB, aluResult;
  logic [5:0]              aluOp;
  logic                    rspValid, rspReady, busy;
  logic [ID_W-1:0]         rspId;
  logic [31:0]             rspData;
  logic [15:0]             opCount;

  rsp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_op     (reqOp),
    .req_a      (reqA),
    .req_b      (reqB),
    .alu_a      (aluA),
    .alu_b      (aluB),
    .alu_op     (aluOp),
    .alu_result (aluResult),
    .rsp_valid  (rspValid),
    .rsp_ready  (rspReady),
    .rsp_id     (rspId),
    .rsp_data   (rspData),
    .busy       (busy),
    .op_count   (opCount)
  );

  always #5 clk = ~clk;

  // Reference ALU core that sits beside the arbiter.
  always_comb begin
    case (aluOp[5:4])
      UNIT_ADDSUB: aluResult = aluOp[3] ? (aluA - aluB) : (aluA + aluB);
      UNIT_CMP:    aluResult = {31'd0, (aluA < aluB)};
      UNIT_LOGIC:  aluResult = aluA & aluB;
      default:     aluResult = aluA << aluB[4:0];
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Raise one request (called just after a rising edge), wait for its grant,
  // and withdraw it right after the accepting edge.
  task automatic applyStimulus(input int id, input logic [5:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               output int waitCycles);
    reqOp[6*id +: 6]  = op;
    reqA[32*id +: 32] = a;
    reqB[32*id +: 32] = b;
    reqValid[id]      = 1'b1;
    waitCycles        = 0;
    @(negedge clk);
    while (!reqReady[id] && waitCycles < 50) begin
      waitCycles++;
      @(negedge clk);
    end
    checkOutput("grant_seen", 32'(reqReady[id]), 32'd1);
    @(posedge clk);
    #1;
    reqValid[id] = 1'b0;
  endtask

  // Wait (bounded) until the arbiter drops back to IDLE, then align after an edge.
  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("idle_reached", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response handshake is checked against the queue head.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && rspValid && rspReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got id %0d data 0x%08h, expected no response",
                 rspId, rspData);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_id", 32'(rspId), 32'(e.id));
        checkOutput("rsp_data", rspData, e.data);
      end
    end
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int waitCycles;
  int rrOrder[5] = '{0, 1, 2, 3, 0};
  longint lastGrant;

  // Directed sequence of scenarios.
  initial begin
    rst = 1'b1; reqValid = '0; reqOp = '0; reqA = '0; reqB = '0; rspReady = 1'b1;
    lastGrant = 0;

    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_op_count", 32'(opCount), 32'd0);
    checkOutput("reset_rsp_data", rspData, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    reqValid = 4'b1111;
    #1;
    checkOutput("reset_prio_grant", 32'(reqReady), 32'h1);
    reqValid = '0;
    @(posedge clk); #1;

    // Single add from requester 2
    $display("[TB] single add");
    expQ.push_back('{id: 2'd2, data: 32'd8});
    applyStimulus(2, 6'b000000, 32'd5, 32'd3, waitCycles);
    checkOutput("add_ready_same_cycle", 32'(waitCycles), 32'd0);
    @(negedge clk);
    checkOutput("exec_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("exec_busy", 32'(busy), 32'd1);
    checkOutput("exec_alu_a", aluA, 32'd5);
    @(negedge clk);
    checkOutput("resp_rsp_valid", 32'(rspValid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("add_op_count", 32'(opCount), 32'd1);
    @(posedge clk); #1;

    // Subtract from requester 1
    $display("[TB] subtract");
    expQ.push_back('{id: 2'd1, data: 32'hFFFF_FFFE});
    applyStimulus(1, 6'b001000, 32'd3, 32'd5, waitCycles);
    waitIdle();
    checkOutput("sub_op_count", 32'(opCount), 32'd2);

    // Backpressure with a competing request pending
    $display("[TB] backpressure");
    rspReady = 1'b0;
    expQ.push_back('{id: 2'd0, data: 32'd123});
    applyStimulus(0, 6'b000000, 32'd100, 32'd23, waitCycles);
    reqOp[18 +: 6] = 6'b000000; reqA[96 +: 32] = 32'd7; reqB[96 +: 32] = 32'd9;
    reqValid[3] = 1'b1;
    @(negedge clk);
    checkOutput("bp_exec_req_ready", 32'(reqReady), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rspValid), 32'd1);
      checkOutput("bp_rsp_id", 32'(rspId), 32'd0);
      checkOutput("bp_rsp_data", rspData, 32'd123);
      checkOutput("bp_req_ready", 32'(reqReady), 32'd0);
      checkOutput("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    rspReady = 1'b1;
    expQ.push_back('{id: 2'd3, data: 32'd16});
    applyStimulus(3, 6'b000000, 32'd7, 32'd9, waitCycles);
    checkOutput("bp_next_accept_delay", 32'(waitCycles), 32'd1);
    waitIdle();
    checkOutput("bp_op_count", 32'(opCount), 32'd4);

    // Reset during EXEC drops the operation
    $display("[TB] reset mid-op");
    applyStimulus(2, 6'b000000, 32'd1, 32'd1, waitCycles);
    @(negedge clk);
    checkOutput("midop_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midop_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("midop_busy", 32'(busy), 32'd0);
    checkOutput("midop_req_ready", 32'(reqReady), 32'd0);
    checkOutput("midop_op_count", 32'(opCount), 32'd0);
    checkOutput("midop_alu_a", aluA, 32'd0);
    checkOutput("midop_alu_op", 32'(aluOp), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    checkOutput("midop_still_quiet", 32'(rspValid), 32'd0);
    rst = 1'b0;

    // Round-robin with all requesters asserting continuously
    $display("[TB] round robin");
    for (int i = 0; i < NUM_REQ; i++) begin
      reqOp[6*i +: 6]  = 6'b000000;
      reqA[32*i +: 32] = 32'(i * 10);
      reqB[32*i +: 32] = 32'd1;
    end
    for (int g = 0; g < 5; g++)
      expQ.push_back('{id: ID_W'(rrOrder[g]), data: 32'(rrOrder[g] * 10 + 1)});
    reqValid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int w = 0;
      @(negedge clk);
      while (reqReady == '0 && w < 20) begin
        w++;
        @(negedge clk);
      end
      checkOutput("rr_grant", 32'(reqReady), 32'd1 << rrOrder[g]);
      if (g > 0) checkOutput("rr_spacing", 32'(($time - lastGrant) / 10), 32'd3);
      lastGrant = $time;
    end
    @(posedge clk); #1;
    reqValid = '0;
    waitIdle();
    checkOutput("rr_op_count", 32'(opCount), 32'd5);

    // Counter wrap from 0xFFFF
    $display("[TB] counter wrap");
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    checkOutput("wrap_preload", 32'(opCount), 32'hFFFF);
    release dut.op_count_q;
    @(posedge clk); #1;
    expQ.push_back('{id: 2'd1, data: 32'd1});
    applyStimulus(1, 6'b010000, 32'd2, 32'd9, waitCycles);
    waitIdle();
    checkOutput("wrap_op_count", 32'(opCount), 32'd0);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
